// File: rtl/krnl_partialknn_local_sp_reader_pkg.sv
// Shared defaults and FSM state type for the search-point reader.
// Widths/latency here are the defaults the reader and its testbench build against.
package krnl_partialknn_local_sp_reader_pkg;

  localparam int unsigned SP_DATA_WIDTH = 256;
  localparam int unsigned SP_ADDR_WIDTH = 11;
  localparam int unsigned SP_DEPTH      = 2048;
  localparam int unsigned SP_RD_LAT     = 2;
  localparam int unsigned SP_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sp_state_e;

endpackage

// File: rtl/krnl_partialknn_local_sp_reader_fifo.sv
// First-word-fall-through FIFO with occupancy count; zero-latency head, one entry per cycle.
// Backpressure: head holds while rd_rdy_i is low; writes are refused only when full and not draining.
module krnl_partialKnn_sp_fifo #(
  parameter int unsigned WIDTH = 257,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_vld_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  output logic             rd_vld_o,
  input  logic             rd_rdy_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_en, rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign rd_vld_o = (cnt_q != '0);
  assign rd_en    = rd_vld_o && rd_rdy_i;
  assign wr_en    = wr_vld_i && ((cnt_q != CW'(DEPTH)) || rd_en);
  assign rd_dat_o = mem_q[rptr_q];
  assign count_o  = cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wptr_q <= ptr_inc(wptr_q);
      if (rd_en) rptr_q <= ptr_inc(rptr_q);
      cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/krnl_partialknn_local_sp_reader.sv
// Streams num_words URAM entries from base_addr (wrapping) to the distance stage; first word RD_LAT+2 after start.
// Backpressure: reads issue only while in-flight plus buffered words fit the output FIFO, so nothing is dropped.
module krnl_partialknn_local_sp_reader
  import krnl_partialknn_local_sp_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SP_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = SP_ADDR_WIDTH,
  parameter int unsigned DEPTH      = SP_DEPTH,
  parameter int unsigned RD_LAT     = SP_RD_LAT,
  parameter int unsigned FIFO_DEPTH = SP_FIFO_DEPTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address0,
  output logic                  mem_ce0,
  output logic                  mem_we0,
  input  logic [DATA_WIDTH-1:0] mem_q0,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

  sp_state_e             state_q, state_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   num_q, issued_q;
  logic [RD_LAT-1:0]     sr_vld_q, sr_last_q;
  logic [CW-1:0]         fifo_cnt;
  logic [DATA_WIDTH:0]   fifo_head;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic [31:0]           occ;
  logic                  start_ok, rd_last;

  assign start_ok = start && (state_q == ST_IDLE);
  assign rd_last  = (issued_q == num_q - ONE_W);
  assign addr_sum = {1'b0, base_q} + issued_q;
  assign mem_address0 = (addr_sum >= DEPTH_W) ? ADDR_WIDTH'(addr_sum - DEPTH_W)
                                              : addr_sum[ADDR_WIDTH-1:0];
  assign mem_we0  = 1'b0;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

  // Words already committed to the FIFO: still in the URAM pipe plus already buffered.
  assign occ = 32'(fifo_cnt) + 32'($countones(sr_vld_q));

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    mem_ce0 = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_words == '0) done_d = 1'b1;
          else                 state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if ((issued_q < num_q) && (occ < FIFO_DEPTH)) begin
          mem_ce0 = 1'b1;
          if (rd_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q   <= ST_IDLE;
      done_q    <= 1'b0;
      base_q    <= '0;
      num_q     <= '0;
      issued_q  <= '0;
      sr_vld_q  <= '0;
      sr_last_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (start_ok) begin
        base_q   <= base_addr;
        num_q    <= num_words;
        issued_q <= '0;
      end else if (mem_ce0) begin
        issued_q <= issued_q + ONE_W;
      end
      // Valid/last ride alongside the URAM read pipe so mem_q0 is captured exactly when it lands.
      sr_vld_q  <= RD_LAT'({sr_vld_q, mem_ce0});
      sr_last_q <= RD_LAT'({sr_last_q, rd_last});
    end
  end

  krnl_partialKnn_sp_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (ap_clk),
    .rst_ni   (ap_rst_n),
    .wr_vld_i (sr_vld_q[RD_LAT-1]),
    .wr_dat_i ({sr_last_q[RD_LAT-1], mem_q0}),
    .rd_vld_o (out_valid),
    .rd_rdy_i (out_ready),
    .rd_dat_o (fifo_head),
    .count_o  (fifo_cnt)
  );

  assign out_data = fifo_head[DATA_WIDTH-1:0];
  assign out_last = out_valid && fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_krnl_partialknn_local_sp_reader.sv
// Directed scoreboard bench for the search-point reader: stimulus queues expectations, a negedge monitor checks.
module tb_krnl_partialknn_local_sp_reader;

  localparam int DW    = 256;
  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  logic          ap_clk    = 1'b0;
  logic          ap_rst_n  = 1'b0;
  logic          start     = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   num_words = '0;
  logic          busy, done, mem_ce0, mem_we0, out_valid, out_last;
  logic [AW-1:0] mem_address0;
  logic [DW-1:0] mem_q0, out_data;
  logic [DW-1:0] d1_q, d2_q;
  int            cyc = 0;

  typedef struct {
    int   t;
    int   base;
    int   num;
    logic timed;
    int   fce, lce, fval, lval, dt;
  } blk_t;

  blk_t          exp_q[$];
  logic [DW:0]   sb_q[$];

  int total = 0, bad = 0;
  int ce_n = 0, val_n = 0, hs_n = 0, busy_n = 0, max_out = 0;
  int fce_c = 0, lce_c = 0, fval_c = 0, lval_c = 0;
  int dn_tot = 0, tmo_cnt = 0;
  logic          hold_pend = 1'b0, hold_last = 1'b0;
  logic [DW-1:0] hold_dat = '0;
  logic          fin_req = 1'b0, fin_seen = 1'b0;
  blk_t          e_m;
  logic [DW:0]   w_m;

  krnl_partialknn_local_sp_reader dut (
    .ap_clk       (ap_clk),
    .ap_rst_n     (ap_rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .mem_address0 (mem_address0),
    .mem_ce0      (mem_ce0),
    .mem_we0      (mem_we0),
    .mem_q0       (mem_q0),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mk_word(input int a);
    logic [31:0] s;
    s = (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    return {s, {7{32'(a)}}};
  endfunction

  // URAM model: RD_LAT=2 registered read; garbage when ce0 is low so stray captures show up.
  always @(posedge ap_clk) begin
    d1_q <= mem_ce0 ? mk_word(int'(mem_address0)) : {8{32'hDEAD_BEEF}};
    d2_q <= d1_q;
  end
  assign mem_q0 = d2_q;

  task automatic chk_i(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clr_stats();
    ce_n = 0; val_n = 0; hs_n = 0; busy_n = 0; max_out = 0;
    fce_c = 0; lce_c = 0; fval_c = 0; lval_c = 0;
  endtask

  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      chk_i("rst_busy",  int'(busy),         0);
      chk_i("rst_done",  int'(done),         0);
      chk_i("rst_ce0",   int'(mem_ce0),      0);
      chk_i("rst_addr",  int'(mem_address0), 0);
      chk_i("rst_valid", int'(out_valid),    0);
      chk_i("rst_last",  int'(out_last),     0);
      sb_q.delete();
      exp_q.delete();
      clr_stats();
      hold_pend = 1'b0;
    end else begin
      if (mem_ce0) begin
        chk_i("we0", int'(mem_we0), 0);
        if (exp_q.size() == 0) chk_i("ce_without_block", exp_q.size(), 1);
        else chk_i("rd_addr", int'(mem_address0), (exp_q[0].base + ce_n) % DEPTH);
        if (ce_n == 0) fce_c = cyc;
        lce_c = cyc;
        ce_n++;
        if (ce_n - hs_n > max_out) max_out = ce_n - hs_n;
      end
      if (hold_pend) begin
        chk_i("stall_valid", int'(out_valid), 1);
        chk_w("stall_data",  out_data, hold_dat);
        chk_i("stall_last",  int'(out_last), int'(hold_last));
      end
      if (out_valid) begin
        if (val_n == 0) fval_c = cyc;
        lval_c = cyc;
        val_n++;
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) chk_i("extra_word", sb_q.size(), 1);
        else begin
          w_m = sb_q.pop_front();
          chk_w("word_data", out_data, w_m[DW-1:0]);
          chk_i("word_last", int'(out_last), int'(w_m[DW]));
        end
        hs_n++;
      end
      hold_pend = out_valid && !out_ready;
      hold_dat  = out_data;
      hold_last = out_last;
      if (busy) busy_n++;
      if (done) begin
        dn_tot++;
        chk_i("done_busy", int'(busy), 0);
        if (exp_q.size() == 0) chk_i("done_without_block", exp_q.size(), 1);
        else begin
          e_m = exp_q.pop_front();
          chk_i("ce_count", ce_n, e_m.num);
          chk_i("max_outstanding", max_out, (e_m.num < 4) ? e_m.num : 4);
          chk_i("words_left", sb_q.size(), 0);
          if (e_m.timed) begin
            chk_i("done_cycle",   cyc,    e_m.t + e_m.dt);
            chk_i("busy_cycles",  busy_n, e_m.dt - 1);
            chk_i("valid_cycles", val_n,  e_m.num);
            if (e_m.num > 0) begin
              chk_i("first_ce",    fce_c,  e_m.t + e_m.fce);
              chk_i("last_ce",     lce_c,  e_m.t + e_m.lce);
              chk_i("first_valid", fval_c, e_m.t + e_m.fval);
              chk_i("last_valid",  lval_c, e_m.t + e_m.lval);
            end
          end
        end
        clr_stats();
      end
    end
    if (fin_req && !fin_seen) begin
      chk_i("timeouts",        tmo_cnt,      0);
      chk_i("final_words",     sb_q.size(),  0);
      chk_i("final_blocks",    exp_q.size(), 0);
      fin_seen = 1'b1;
    end
  end

  task automatic go(input int base, input int num, input logic timed,
                    input int fce, input int lce, input int fval, input int lval, input int dt);
    blk_t e;
    @(posedge ap_clk); #1;
    e.t = cyc; e.base = base; e.num = num; e.timed = timed;
    e.fce = fce; e.lce = lce; e.fval = fval; e.lval = lval; e.dt = dt;
    exp_q.push_back(e);
    for (int i = 0; i < num; i++) sb_q.push_back({(i == num - 1), mk_word((base + i) % DEPTH)});
    base_addr = AW'(base);
    num_words = (AW + 1)'(num);
    start     = 1'b1;
    @(posedge ap_clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int  d0;
    bit  ok;
    d0 = dn_tot;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge ap_clk); #1;
      if (dn_tot != d0) begin ok = 1'b1; break; end
    end
    if (!ok) tmo_cnt++;
  endtask

  initial begin
    bit hs_ok;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (2) @(posedge ap_clk);

    // base 0, 8 words, ready high: ce T+1..T+8, valid T+4..T+11, done T+12
    go(0, 8, 1'b1, 1, 8, 4, 11, 12);
    wait_done(60);
    // wrap across the top of the buffer
    go(2044, 6, 1'b1, 1, 6, 4, 9, 10);
    wait_done(60);
    // empty block: done at T+1, no reads, no output
    go(7, 0, 1'b1, 0, 0, 0, 0, 1);
    wait_done(20);
    // second start one cycle into a block must be ignored
    go(500, 4, 1'b1, 1, 4, 4, 7, 8);
    start = 1'b1; base_addr = AW'(0); num_words = (AW + 1)'(8);
    @(posedge ap_clk); #1;
    start = 1'b0;
    wait_done(60);

    // 16 words with ready toggling and a 10-cycle stall
    go(300, 16, 1'b0, 0, 0, 0, 0, 0);
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge ap_clk); #1;
          out_ready = (i >= 8 && i < 18) ? 1'b0 : ((i % 2) == 0);
        end
        out_ready = 1'b1;
      end
      wait_done(200);
    join

    // reset three words into a 20-word block, then a clean 2-word block
    go(1000, 20, 1'b0, 0, 0, 0, 0, 0);
    hs_ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge ap_clk); #1;
      if (hs_n >= 3) begin hs_ok = 1'b1; break; end
    end
    if (!hs_ok) tmo_cnt++;
    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    repeat (3) @(posedge ap_clk);
    go(100, 2, 1'b1, 1, 2, 4, 5, 6);
    wait_done(40);

    repeat (4) @(posedge ap_clk);
    #1 fin_req = 1'b1;
    repeat (2) @(negedge ap_clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
